uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Shares one 8N1 byte transmitter (uartByteTx) between N_REQ byte-stream requesters using round-robin arbitration with packet locking. A granted requester keeps the transmitter until its byte flagged last has been sent. The block sequences each byte (start pulse, busy wait, done wait) and inserts a programmable inter-byte idle gap. It sits between the per-source stream producers (e.g. register-mapped TX slaves) and the single uartByteTx instance driving the TXD pin.

Parameters:
N_REQ, 4, number of requesters (2..16)
GAP_CYCLES, 0, idle i_clk cycles inserted after each byte's done pulse before the next start (0..65535)
BUSY_TIMEOUT, 4, cycles allowed between start pulse and i_txBusy high before flagging error (>=2)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous reset, active-high
i_reqValid  in  N_REQ  per-requester byte valid
i_reqData  in  8*N_REQ  per-requester byte; requester k at bits [8k+7:8k]
i_reqLast  in  N_REQ  per-requester last-byte-of-packet flag
o_reqReady  out  N_REQ  one-hot byte accept strobe, one cycle
o_grant  out  N_REQ  one-hot current owner; 0 when idle
o_txData  out  8  byte to transmitter
o_txStart  out  1  start pulse to transmitter
i_txBusy  in  1  transmitter busy
i_txDone  in  1  transmitter done pulse
o_pktDone  out  N_REQ  one-cycle pulse when a requester's last byte finishes
o_err  out  1  sticky: busy-timeout occurred; cleared only by reset

Behaviour:
- Reset values: o_reqReady=0, o_grant=0, o_txData=0, o_txStart=0, o_pktDone=0, o_err=0; state IDLE; RR pointer=0.
- States: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, GAP.
- IDLE: if any i_reqValid, select first valid index searching upward from RR pointer, wrapping modulo N_REQ; set o_grant one-hot; go LOAD next cycle. No valid: stay.
- LOAD (owner k): if i_reqValid[k], register o_txData=i_reqData[k], latch last flag, pulse o_reqReady[k] and o_txStart for exactly this cycle, go WAIT_BUSY. If owner has deasserted valid mid-packet, hold grant and wait in LOAD (packet lock; no preemption).
- WAIT_BUSY: counter from 1; i_txBusy=1 -> WAIT_DONE. Counter reaching BUSY_TIMEOUT without busy -> set o_err, release grant, advance RR pointer to k+1, go IDLE (byte counted lost, no o_pktDone).
- WAIT_DONE: on i_txDone -> GAP if GAP_CYCLES>0, else decide immediately (same as GAP exit).
- GAP: count GAP_CYCLES cycles; o_txStart held 0. Exit decision: latched last=1 -> pulse o_pktDone[k], clear o_grant, RR pointer=k+1 mod N_REQ, go IDLE; else go LOAD with same owner.
- Latency: valid in IDLE -> o_txStart two cycles later. Back-to-back bytes in a packet with GAP_CYCLES=0: start is issued 1 cycle after done.
- o_txData holds value from LOAD until next LOAD (stable for transmitter sampling).
- Simultaneous i_txDone with i_txBusy still high is treated as done.
- Unexpected i_txDone outside WAIT_DONE ignored.
- Reset mid-byte: all state cleared asynchronously; the transmitter resets on the same i_rst.
- i_reqValid for non-owners ignored while granted; their o_reqReady stay 0.

Decomposition:
- Package uart_tx_arb_pkg: state enum encoding, IDX_W = clog2(N_REQ) function, GAP/timeout counter width constants (16 bit).
- Sub-module rr_pick: combinational round-robin selector (valid vector, pointer -> one-hot grant + index); reused by future RX-side schedulers.

Test Plan:
- Single packet: req0 sends 0x55,0xA3(last), transmitter model 10 cycles/bit -> two o_txStart pulses, o_txData 0x55 then 0xA3, o_pktDone[0] once, o_grant returns 0.
- Fairness: req0..3 each hold valid with single-byte packets continuously -> grant order 0,1,2,3,0,1; no requester starved.
- Packet lock: req1 3-byte packet, req2 valid throughout, req1 drops valid 50 cycles between bytes 2 and 3 -> grant stays on req1 until its last byte done, then req2.
- Gap: GAP_CYCLES=20 -> cycles between i_txDone and next o_txStart = 21.
- Timeout: model never raises busy, BUSY_TIMEOUT=4 -> o_err=1 after 4 cycles, grant released, next requester served, o_err stays 1.
- Reset mid-byte: assert i_rst during WAIT_DONE -> all outputs 0 immediately, after release req3 arbitrated first if only valid.

Source files
------------

// File: rtl/uart_tx_arb_pkg.sv
// rtl/uart_tx_arb_pkg.sv - shared types and constants for the UART TX arbiter
package uart_tx_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } arb_state_e;

    // Shared width of the busy-timeout and inter-byte gap counters.
    localparam int CNT_W = 16;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker: first valid at or above the pointer, wrapping
module rr_pick
    import uart_tx_arb_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     i_valid,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int j;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(i_ptr) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!o_any && i_valid[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked sharing of one 8N1 byte transmitter
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int GAP_CYCLES   = 0,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   i_reqValid,
    input  logic [8*N_REQ-1:0] i_reqData,
    input  logic [N_REQ-1:0]   i_reqLast,
    output logic [N_REQ-1:0]   o_reqReady,
    output logic [N_REQ-1:0]   o_grant,
    output logic [7:0]         o_txData,
    output logic               o_txStart,
    input  logic               i_txBusy,
    input  logic               i_txDone,
    output logic [N_REQ-1:0]   o_pktDone,
    output logic               o_err
);

    localparam int               IDX_W     = idx_w(N_REQ);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT);

    arb_state_e       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] ptr_q;
    logic             last_q;
    logic [CNT_W-1:0] cnt_q;
    logic [N_REQ-1:0] grant_q;
    logic [N_REQ-1:0] ready_q;
    logic [N_REQ-1:0] pkt_done_q;
    logic [7:0]       tx_data_q;
    logic             tx_start_q;
    logic             err_q;

    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_valid (i_reqValid),
        .i_ptr   (ptr_q),
        .o_grant (pick_grant),
        .o_idx   (pick_idx),
        .o_any   (pick_any)
    );

    logic [N_REQ-1:0] owner_1h;
    logic [IDX_W-1:0] next_ptr;
    logic             owner_valid;
    logic             decide;
    logic             load_fire;

    assign owner_1h    = N_REQ'(1) << owner_q;
    assign next_ptr    = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign owner_valid = i_reqValid[owner_q];

    // End of a byte's slot: straight off the done pulse without a gap, else at the last gap cycle.
    assign decide    = (state_q == ST_WAIT_DONE && i_txDone && GAP_CYCLES == 0) ||
                       (state_q == ST_GAP && cnt_q == GAP_LAST);
    // Mid-packet bytes load on the decision cycle itself so the next start follows immediately.
    assign load_fire = owner_valid && (state_q == ST_LOAD || (decide && !last_q));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            last_q     <= 1'b0;
            cnt_q      <= '0;
            grant_q    <= '0;
            ready_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            pkt_done_q <= '0;
            err_q      <= 1'b0;
        end else begin
            ready_q    <= '0;
            tx_start_q <= 1'b0;
            pkt_done_q <= '0;
            if (load_fire) begin
                tx_data_q  <= i_reqData[8*owner_q +: 8];
                last_q     <= i_reqLast[owner_q];
                ready_q    <= owner_1h;
                tx_start_q <= 1'b1;
                cnt_q      <= CNT_W'(1);
                state_q    <= ST_WAIT_BUSY;
            end else if (decide && last_q) begin
                pkt_done_q <= owner_1h;
                grant_q    <= '0;
                ptr_q      <= next_ptr;
                state_q    <= ST_IDLE;
            end else if (decide) begin
                state_q <= ST_LOAD;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pick_any) begin
                            grant_q <= pick_grant;
                            owner_q <= pick_idx;
                            state_q <= ST_LOAD;
                        end
                    end
                    ST_WAIT_BUSY: begin
                        if (i_txBusy) begin
                            state_q <= ST_WAIT_DONE;
                        end else if (cnt_q == BUSY_LAST) begin
                            err_q   <= 1'b1;
                            grant_q <= '0;
                            ptr_q   <= next_ptr;
                            state_q <= ST_IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_WAIT_DONE: begin
                        if (i_txDone) begin
                            cnt_q   <= CNT_W'(1);
                            state_q <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_reqReady = ready_q;
    assign o_grant    = grant_q;
    assign o_txData   = tx_data_q;
    assign o_txStart  = tx_start_q;
    assign o_pktDone  = pkt_done_q;
    assign o_err      = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (gap 0 and gap 20 instances)
module tb_uart_tx_arbiter;

    localparam int BYTE_CYC   = 100;
    localparam int BYTE_CYC_G = 30;
    localparam int LIM        = 400;
    localparam int LIM_DRAIN  = 3000;

    localparam int W_START = 0, W_DONE = 1, W_ERR = 2, W_GSTART = 3;
    localparam int W_GDONE = 4, W_GPKT = 5, W_VALID0 = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_last  = '0;
    logic [3:0]  req_ready;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic        tx_done = 1'b0;
    logic [3:0]  pkt_done;
    logic        err;
    logic        no_busy = 1'b0;

    logic [3:0]  g_valid = '0;
    logic [31:0] g_data  = '0;
    logic [3:0]  g_last  = '0;
    logic [3:0]  g_ready;
    logic [3:0]  g_grant;
    logic [7:0]  g_tx_data;
    logic        g_start;
    logic        g_busy = 1'b0;
    logic        g_done = 1'b0;
    logic [3:0]  g_pkt_done;
    logic        g_err;

    int bcnt   = 0;
    int g_bcnt = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] data;
        bit         pkt;
    } exp_t;

    exp_t       sb_q[$];
    logic [3:0] pkt_q[$];
    exp_t       mon_e;
    logic [3:0] mon_p;

    logic [8:0] src_mem [4][8];
    int         src_head [4];
    int         src_tail [4];

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(0), .BUSY_TIMEOUT(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_reqValid (req_valid),
        .i_reqData  (req_data),
        .i_reqLast  (req_last),
        .o_reqReady (req_ready),
        .o_grant    (grant),
        .o_txData   (tx_data),
        .o_txStart  (tx_start),
        .i_txBusy   (tx_busy),
        .i_txDone   (tx_done),
        .o_pktDone  (pkt_done),
        .o_err      (err)
    );

    uart_tx_arbiter #(.N_REQ(4), .GAP_CYCLES(20), .BUSY_TIMEOUT(4)) dut_g (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_reqValid (g_valid),
        .i_reqData  (g_data),
        .i_reqLast  (g_last),
        .o_reqReady (g_ready),
        .o_grant    (g_grant),
        .o_txData   (g_tx_data),
        .o_txStart  (g_start),
        .i_txBusy   (g_busy),
        .i_txDone   (g_done),
        .o_pktDone  (g_pkt_done),
        .o_err      (g_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic src_push(input int k, input logic [7:0] d, input logic last);
        src_mem[k][src_tail[k]] = {last, d};
        src_tail[k]++;
    endtask

    task automatic sb_push(input int k, input logic [7:0] d, input bit pkt);
        exp_t e;
        e.grant = 4'(1 << k);
        e.data  = d;
        e.pkt   = pkt;
        sb_q.push_back(e);
    endtask

    function automatic bit sig_sel(input int which);
        case (which)
            W_START:  return tx_start;
            W_DONE:   return tx_done;
            W_ERR:    return err;
            W_GSTART: return g_start;
            W_GDONE:  return g_done;
            W_GPKT:   return g_pkt_done[0];
            W_VALID0: return req_valid[0];
            default:  return 1'b0;
        endcase
    endfunction

    // Advances at least one negedge; n is the number of negedges until the signal is seen.
    task automatic wait_for(input int which, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig_sel(which) && n < LIM);
        chk({tag, "_seen"}, 32'(sig_sel(which)), 32'd1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || pkt_q.size() != 0) && n < LIM_DRAIN) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk({tag, "_drained"}, 32'(n < LIM_DRAIN), 32'd1);
    endtask

    // Requester sources and the two transmitter models, all updated just after each rising edge.
    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (req_ready[k] && src_head[k] != src_tail[k]) src_head[k]++;
            req_valid[k] = (src_head[k] != src_tail[k]);
            {req_last[k], req_data[8*k +: 8]} = src_mem[k][src_head[k]];
        end
        if (rst) begin
            tx_busy = 1'b0; tx_done = 1'b0; bcnt = 0;
            g_busy  = 1'b0; g_done  = 1'b0; g_bcnt = 0;
        end else begin
            if (tx_done) begin
                tx_done = 1'b0; tx_busy = 1'b0;
            end else if (tx_busy) begin
                if (bcnt == BYTE_CYC - 1) tx_done = 1'b1;
                else bcnt++;
            end
            if (!tx_busy && tx_start && !no_busy) begin
                tx_busy = 1'b1; bcnt = 0;
            end
            if (g_done) begin
                g_done = 1'b0; g_busy = 1'b0;
            end else if (g_busy) begin
                if (g_bcnt == BYTE_CYC_G - 1) g_done = 1'b1;
                else g_bcnt++;
            end
            if (!g_busy && g_start) begin
                g_busy = 1'b1; g_bcnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (tx_start) begin
                chk("start_expected", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    chk("tx_data", 32'(tx_data), 32'(mon_e.data));
                    chk("grant_at_start", 32'(grant), 32'(mon_e.grant));
                    chk("req_ready", 32'(req_ready), 32'(mon_e.grant));
                    if (mon_e.pkt) pkt_q.push_back(mon_e.grant);
                end
            end
            if (pkt_done != 4'd0) begin
                chk("pkt_done_expected", 32'(pkt_q.size() != 0), 32'd1);
                if (pkt_q.size() != 0) begin
                    mon_p = pkt_q.pop_front();
                    chk("pkt_done", 32'(pkt_done), 32'(mon_p));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_pkt_done", 32'(pkt_done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;

        // fairness: every requester holds two single-byte packets
        for (int i = 0; i < 8; i++) begin
            src_push(i % 4, 8'(8'h10 + i), 1'b1);
            sb_push(i % 4, 8'(8'h10 + i), 1'b1);
        end
        drain("fair");
        chk("fair_idle_grant", 32'(grant), 32'd0);

        // single two-byte packet on req0
        src_push(0, 8'h55, 1'b0);
        src_push(0, 8'hA3, 1'b1);
        sb_push(0, 8'h55, 1'b0);
        sb_push(0, 8'hA3, 1'b1);
        wait_for(W_VALID0, "single_valid", n);
        wait_for(W_START, "single_start", n);
        chk("single_latency", 32'(n), 32'd2);
        wait_for(W_DONE, "single_done", n);
        wait_for(W_START, "b2b_start", n);
        chk("b2b_latency", 32'(n), 32'd1);
        drain("single");
        chk("single_idle_grant", 32'(grant), 32'd0);
        chk("single_data_hold", 32'(tx_data), 32'h0A3);

        // packet lock: req1 stalls 50 cycles before its last byte while req2 waits
        src_push(1, 8'h31, 1'b0);
        src_push(1, 8'h32, 1'b0);
        src_push(2, 8'h40, 1'b1);
        sb_push(1, 8'h31, 1'b0);
        sb_push(1, 8'h32, 1'b0);
        sb_push(1, 8'h33, 1'b1);
        sb_push(2, 8'h40, 1'b1);
        n = 0;
        while (src_head[1] != 2 && n < LIM_DRAIN) begin
            @(negedge clk);
            n++;
        end
        chk("lock_two_taken", 32'(src_head[1]), 32'd2);
        wait_for(W_DONE, "lock_done2", n);
        repeat (50) @(negedge clk);
        chk("lock_grant_held", 32'(grant), 32'b0010);
        chk("lock_req2_not_ready", 32'(req_ready), 32'd0);
        src_push(1, 8'h33, 1'b1);
        drain("lock");
        chk("lock_idle_grant", 32'(grant), 32'd0);

        // busy timeout on req3, then req0 is served normally
        no_busy = 1'b1;
        src_push(3, 8'h70, 1'b1);
        src_push(0, 8'h71, 1'b1);
        sb_push(3, 8'h70, 1'b0);
        sb_push(0, 8'h71, 1'b1);
        wait_for(W_START, "to_start", n);
        wait_for(W_ERR, "to_err", n);
        chk("to_latency", 32'(n), 32'd4);
        chk("to_grant_released", 32'(grant), 32'd0);
        no_busy = 1'b0;
        drain("to");
        chk("to_err_sticky", 32'(err), 32'd1);

        // reset while req1's byte is in flight
        src_push(1, 8'h5A, 1'b1);
        sb_push(1, 8'h5A, 1'b0);
        wait_for(W_START, "rstmid_start", n);
        repeat (20) @(negedge clk);
        chk("rstmid_grant_before", 32'(grant), 32'b0010);
        rst = 1'b1;
        #1;
        chk("rstmid_ready", 32'(req_ready), 32'd0);
        chk("rstmid_grant", 32'(grant), 32'd0);
        chk("rstmid_tx_data", 32'(tx_data), 32'd0);
        chk("rstmid_tx_start", 32'(tx_start), 32'd0);
        chk("rstmid_pkt_done", 32'(pkt_done), 32'd0);
        chk("rstmid_err", 32'(err), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        src_push(3, 8'h77, 1'b1);
        sb_push(3, 8'h77, 1'b1);
        drain("postrst");
        chk("postrst_idle_grant", 32'(grant), 32'd0);

        // 20-cycle gap instance
        g_data  = 32'h11;
        g_last  = 4'b0000;
        g_valid = 4'b0001;
        wait_for(W_GSTART, "gap_first", n);
        chk("gap_data0", 32'(g_tx_data), 32'h11);
        chk("gap_ready0", 32'(g_ready), 32'b0001);
        g_data = 32'h22;
        g_last = 4'b0001;
        wait_for(W_GDONE, "gap_done", n);
        wait_for(W_GSTART, "gap_second", n);
        chk("gap_spacing", 32'(n), 32'd21);
        chk("gap_data1", 32'(g_tx_data), 32'h22);
        g_valid = 4'b0000;
        wait_for(W_GPKT, "gap_pkt", n);
        chk("gap_pkt_done", 32'(g_pkt_done), 32'b0001);
        chk("gap_err", 32'(g_err), 32'd0);
        @(negedge clk);
        chk("gap_idle_grant", 32'(g_grant), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
